// File: rtl/int_ctrl_pkg.sv
// Shared definitions for the interrupt source controller: code width,
// register map indices (addr_i[3:2]) and the one-hot FSM encoding.
package int_ctrl_pkg;

   localparam int               INT_BUS  = 8;
   localparam logic [INT_BUS-1:0] INT_NONE = '0;

   localparam logic [1:0] REG_ENABLE  = 2'd0;
   localparam logic [1:0] REG_PENDING = 2'd1;
   localparam logic [1:0] REG_TRIGGER = 2'd2;
   localparam logic [1:0] REG_ACTIVE  = 2'd3;

   typedef enum logic [2:0] {
      ST_IDLE = 3'b001,
      ST_REQ  = 3'b010,
      ST_SVC  = 3'b100
   } state_e;

endpackage

// File: rtl/int_sync.sv
// Per-source synchroniser: STAGES-deep flop chain plus a one-cycle-delayed
// copy of the synchronised level for rising-edge detection.
module int_sync #(
   parameter int STAGES = 2
) (
   input  logic clk,
   input  logic rst,
   input  logic d_i,
   output logic sync_o,
   output logic prev_o
);

   logic [STAGES-1:0] chain_q, chain_d;
   logic              prev_q,  prev_d;

   always_comb begin
      chain_d = {chain_q[STAGES-2:0], d_i};
      prev_d  = chain_q[STAGES-1];
   end

   // NOTE: nonblocking assignments make every stage capture its neighbour's
   // pre-edge value, so the chain shifts by exactly one stage per clock.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         chain_q <= '0;
         prev_q  <= 1'b0;
      end else begin
         chain_q <= chain_d;
         prev_q  <= prev_d;
      end
   end

   assign sync_o = chain_q[STAGES-1];
   assign prev_o = prev_q;

endmodule

// File: rtl/int_ctrl.sv
// Interrupt source controller: synchronises requests, tracks edge/level pending
// state, masks by ENABLE and presents a fixed-priority code held until ack.
module int_ctrl
   import int_ctrl_pkg::*;
#(
   parameter int NUM_SRC     = 8,
   parameter int SYNC_STAGES = 2
) (
   input  logic                clk,
   input  logic                rst,
   input  logic [NUM_SRC-1:0]  irq_i,
   input  logic                we_i,
   input  logic [31:0]         addr_i,
   input  logic [31:0]         data_i,
   output logic [31:0]         data_o,
   input  logic                int_ack_i,
   input  logic                int_done_i,
   output logic [INT_BUS-1:0]  int_flag_o
);

   localparam int IDX_W = (NUM_SRC > 1) ? $clog2(NUM_SRC) : 1;

   function automatic logic [IDX_W-1:0] prio_enc(input logic [NUM_SRC-1:0] v);
      prio_enc = '0;
      for (int i = NUM_SRC - 1; i >= 0; i--) begin
         if (v[i]) prio_enc = IDX_W'(i);
      end
   endfunction

   state_e               state_q,     state_d;
   logic [IDX_W-1:0]     winner_q,    winner_d;
   logic [INT_BUS-1:0]   flag_q,      flag_d;
   logic [INT_BUS-1:0]   active_q,    active_d;
   logic [NUM_SRC-1:0]   enable_q,    enable_d;
   logic [NUM_SRC-1:0]   trigger_q,   trigger_d;
   logic [NUM_SRC-1:0]   edge_pend_q, edge_pend_d;

   logic [NUM_SRC-1:0]   sync_lvl, sync_prev, pending, eligible, ack_clr;
   logic [IDX_W-1:0]     win_idx;
   logic                 wr_enable, wr_pending, wr_trigger;
   logic                 unused_bits;

   for (genvar g = 0; g < NUM_SRC; g++) begin : g_sync
      int_sync #(.STAGES(SYNC_STAGES)) u_sync (
         .clk    (clk),
         .rst    (rst),
         .d_i    (irq_i[g]),
         .sync_o (sync_lvl[g]),
         .prev_o (sync_prev[g])
      );
   end

   assign wr_enable  = we_i && (addr_i[3:2] == REG_ENABLE);
   assign wr_pending = we_i && (addr_i[3:2] == REG_PENDING);
   assign wr_trigger = we_i && (addr_i[3:2] == REG_TRIGGER);
   assign unused_bits = ^{addr_i[31:4], addr_i[1:0], data_i};

   // Level sources bypass the pending flops and report the synchronised input.
   assign pending  = (trigger_q & edge_pend_q) | (~trigger_q & sync_lvl);
   assign eligible = pending & enable_q;
   assign win_idx  = prio_enc(eligible);

   always_comb begin
      enable_d  = wr_enable  ? data_i[NUM_SRC-1:0] : enable_q;
      trigger_d = wr_trigger ? data_i[NUM_SRC-1:0] : trigger_q;
      // A fresh edge beats W1C/ack clears; a trigger-type change clears unconditionally.
      edge_pend_d = ((sync_lvl & ~sync_prev & trigger_q)
                     | (edge_pend_q & ~ack_clr
                        & ~(wr_pending ? data_i[NUM_SRC-1:0] & trigger_q : '0)))
                    & ~(wr_trigger ? data_i[NUM_SRC-1:0] ^ trigger_q : '0);
   end

   // NOTE: every output of this block is given a default first, so no path
   // leaves a variable unassigned and no latch is inferred.
   always_comb begin
      state_d  = state_q;
      winner_d = winner_q;
      flag_d   = flag_q;
      active_d = active_q;
      ack_clr  = '0;
      case (state_q)
         ST_IDLE: begin
            active_d = INT_NONE;
            if (|eligible) begin
               state_d  = ST_REQ;
               winner_d = win_idx;
               flag_d   = INT_BUS'(win_idx) + INT_BUS'(1);
               active_d = INT_BUS'(win_idx) + INT_BUS'(1);
            end
         end
         ST_REQ: begin
            if (int_ack_i) begin
               state_d           = ST_SVC;
               flag_d            = INT_NONE;
               ack_clr[winner_q] = 1'b1;
            end else if (!enable_d[winner_q]) begin
               state_d  = ST_IDLE;
               flag_d   = INT_NONE;
               active_d = INT_NONE;
            end
         end
         ST_SVC: begin
            flag_d = INT_NONE;
            if (int_done_i) begin
               state_d  = ST_IDLE;
               active_d = INT_NONE;
            end
         end
         default: begin
            state_d  = ST_IDLE;
            flag_d   = INT_NONE;
            active_d = INT_NONE;
         end
      endcase
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state_q     <= ST_IDLE;
         winner_q    <= '0;
         flag_q      <= INT_NONE;
         active_q    <= INT_NONE;
         enable_q    <= '0;
         trigger_q   <= '0;
         edge_pend_q <= '0;
      end else begin
         state_q     <= state_d;
         winner_q    <= winner_d;
         flag_q      <= flag_d;
         active_q    <= active_d;
         enable_q    <= enable_d;
         trigger_q   <= trigger_d;
         edge_pend_q <= edge_pend_d;
      end
   end

   always_comb begin
      data_o = '0;
      case (addr_i[3:2])
         REG_ENABLE:  data_o[NUM_SRC-1:0] = enable_q;
         REG_PENDING: data_o[NUM_SRC-1:0] = pending;
         REG_TRIGGER: data_o[NUM_SRC-1:0] = trigger_q;
         default:     data_o[INT_BUS-1:0] = active_q;
      endcase
   end

   assign int_flag_o = flag_q;

endmodule
